// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared constants and types for the PLL reconfiguration sequencer.
// Optional readback checking is selected by PLL_CFG_READBACK_EN in pll_cfg_sequencer.
package pll_cfg_pkg;

    // Reconfig core register map
    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_N      = 6'h03;
    localparam logic [5:0] REG_M      = 6'h04;
    localparam logic [5:0] REG_C      = 6'h05;

    // Data written to MODE (waitrequest mode) and START
    localparam logic [31:0] MODE_WAITREQ = 32'h0000_0000;
    localparam logic [31:0] START_GO     = 32'h0000_0001;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_WRQ  = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;
    localparam logic [1:0] ERR_RDBK = 2'd3;

    // One buffered register write
    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MODE_WR,
        ST_WR,
        ST_RD,
        ST_START_WR,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic cmd_t make_cmd(input logic [5:0] addr, input logic [31:0] data);
        cmd_t c;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/pll_cfg_fifo.sv
// pll_cfg_fifo: DEPTH x WIDTH synchronous show-ahead FIFO with flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pll_cfg_fifo
    import pll_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_count   = r_wptr - r_rptr;
    assign o_dout    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

    // Read/write pointers, cleared by reset or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// pll_cfg_sequencer: buffers a burst of PLL reconfig register writes, replays
// them on an Avalon-MM master (MODE, user words, START), then waits for a
// stable PLL lock. A word presented with cmd_last=1 only terminates the burst;
// its address/data are not written.
// Optional feature macro: PLL_CFG_READBACK_EN (read back and compare each user write).
module pll_cfg_sequencer
    import pll_cfg_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned WRQ_TIMEOUT  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned LOCK_STABLE  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_last,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_read,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned WRQ_W = $clog2(WRQ_TIMEOUT + 1);
    localparam int unsigned LTO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned LST_W = $clog2(LOCK_STABLE + 1);

    localparam logic [WRQ_W-1:0] WRQ_LAST   = WRQ_W'(WRQ_TIMEOUT - 1);
    localparam logic [WRQ_W-1:0] WRQ_ONE    = WRQ_W'(1);
    localparam logic [LTO_W-1:0] LTO_LAST   = LTO_W'(LOCK_TIMEOUT - 1);
    localparam logic [LTO_W-1:0] LTO_ONE    = LTO_W'(1);
    localparam logic [LST_W-1:0] LST_LAST   = LST_W'(LOCK_STABLE - 1);
    localparam logic [LST_W-1:0] LST_ONE    = LST_W'(1);
    localparam logic [AW:0]      COUNT_ONE  = (AW+1)'(1);

    state_t            r_state;
    state_t            w_next;

    logic              r_lock_meta;
    logic              r_lock_sync;
    logic [WRQ_W-1:0]  r_wrq_cnt;
    logic [LTO_W-1:0]  r_lock_to;
    logic [LST_W-1:0]  r_stable;
    logic              r_error;
    logic [1:0]        r_err_code;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [AW:0]       w_fifo_count;
    logic [CMD_W-1:0]  w_fifo_dout;
    cmd_t              w_head;
    logic              w_last_entry;
    logic              w_wrq_expire;
    logic              w_enter_err;
    logic [1:0]        w_err_code;

`ifndef PLL_CFG_READBACK_EN
    logic              w_unused_rdata;
    assign w_unused_rdata = ^mgmt_readdata;
`endif

    assign w_accept     = cmd_valid && cmd_ready;
    assign w_push       = w_accept && !cmd_last;
    assign w_flush      = (r_state == ST_ERR);
    assign w_head       = cmd_t'(w_fifo_dout);
    assign w_last_entry = (w_fifo_count == COUNT_ONE);
    assign w_wrq_expire = mgmt_waitrequest && (r_wrq_cnt == WRQ_LAST);
    assign w_enter_err  = (w_next == ST_ERR) && (r_state != ST_ERR);

    assign cmd_ready = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !w_fifo_full;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign done      = (r_state == ST_DONE);
    assign error     = r_error;
    assign err_code  = r_err_code;

    pll_cfg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (make_cmd(cmd_addr, cmd_data)),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Avalon master outputs; bus signals derive from state so reset drops them at once
    always_comb begin
        w_next         = r_state;
        mgmt_write     = 1'b0;
        mgmt_read      = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        w_pop          = 1'b0;
        w_err_code     = ERR_NONE;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = cmd_last ? ST_MODE_WR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && cmd_last) begin
                    w_next = ST_MODE_WR;
                end
            end
            ST_MODE_WR: begin
                mgmt_write     = 1'b1;
                mgmt_address   = REG_MODE;
                mgmt_writedata = MODE_WAITREQ;
                if (!mgmt_waitrequest) begin
                    w_next = w_fifo_empty ? ST_START_WR : ST_WR;
                end else if (w_wrq_expire) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_WRQ;
                end
            end
            ST_WR: begin
                mgmt_write     = 1'b1;
                mgmt_address   = w_head.addr;
                mgmt_writedata = w_head.data;
                if (!mgmt_waitrequest) begin
`ifdef PLL_CFG_READBACK_EN
                    // entry stays at the FIFO head until its readback compares
                    w_next = ST_RD;
`else
                    w_pop  = 1'b1;
                    w_next = w_last_entry ? ST_START_WR : ST_WR;
`endif
                end else if (w_wrq_expire) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_WRQ;
                end
            end
`ifdef PLL_CFG_READBACK_EN
            ST_RD: begin
                mgmt_read    = 1'b1;
                mgmt_address = w_head.addr;
                if (!mgmt_waitrequest) begin
                    if (mgmt_readdata == w_head.data) begin
                        w_pop  = 1'b1;
                        w_next = w_last_entry ? ST_START_WR : ST_WR;
                    end else begin
                        w_next     = ST_ERR;
                        w_err_code = ERR_RDBK;
                    end
                end else if (w_wrq_expire) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_WRQ;
                end
            end
`endif
            ST_START_WR: begin
                mgmt_write     = 1'b1;
                mgmt_address   = REG_START;
                mgmt_writedata = START_GO;
                if (!mgmt_waitrequest) begin
                    w_next = ST_WAIT_LOCK;
                end else if (w_wrq_expire) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_WRQ;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lock_sync && (r_stable == LST_LAST)) begin
                    w_next = ST_DONE;
                end else if (r_lock_to == LTO_LAST) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_LOCK;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Per-transfer stall counter: runs only while the same transfer is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrq_cnt <= '0;
        end else if ((mgmt_write || mgmt_read) && mgmt_waitrequest && (w_next == r_state)) begin
            r_wrq_cnt <= r_wrq_cnt + WRQ_ONE;
        end else begin
            r_wrq_cnt <= '0;
        end
    end

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Lock stability and lock timeout counters, active only in WAIT_LOCK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_to <= '0;
            r_stable  <= '0;
        end else if (r_state != ST_WAIT_LOCK) begin
            r_lock_to <= '0;
            r_stable  <= '0;
        end else begin
            r_lock_to <= r_lock_to + LTO_ONE;
            r_stable  <= r_lock_sync ? (r_stable + LST_ONE) : '0;
        end
    end

    // Sticky error status: set on entry to ERR, cleared by the next accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_enter_err) begin
            r_error    <= 1'b1;
            r_err_code <= w_err_code;
        end else if (w_accept) begin
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// tb_pll_cfg_sequencer: directed scoreboard bench for pll_cfg_sequencer.
// Expected Avalon writes are queued when a burst is issued and popped by the
// bus monitor as each write completes. Build with PLL_CFG_READBACK_EN to
// exercise the readback path.
module tb_pll_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_last;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [37:0] sb [$];
    logic [5:0]  b_addr [$];
    logic [31:0] b_data [$];
    logic [31:0] mem [64];

    int   wrq_mode   = 0;
    logic [5:0] stall_addr = '0;
    logic rd_corrupt = 1'b0;
    int   stall_n    = 0;

    int   acc_cnt  = 0;
    int   done_cnt = 0;
    int   wr_cnt   = 0;
    int   rd_cycles = 0;
    logic prev_stall = 1'b0;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;

    pll_cfg_sequencer #(
        .LOCK_TIMEOUT (2000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_data         (cmd_data),
        .cmd_last         (cmd_last),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_read        (mgmt_read),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code)
    );

    always #5 clk = ~clk;

    assign mgmt_readdata = rd_corrupt ? (mem[mgmt_address] ^ 32'h1) : mem[mgmt_address];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave stall model, updated 1 ns after each rising edge
    always @(posedge clk) begin
        #1;
        case (wrq_mode)
            1: begin
                if (mgmt_write || mgmt_read) begin
                    if (stall_n < 5) begin
                        mgmt_waitrequest = 1'b1;
                        stall_n++;
                    end else begin
                        mgmt_waitrequest = 1'b0;
                        stall_n = 0;
                    end
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall_n = 0;
                end
            end
            2: mgmt_waitrequest = (mgmt_write || mgmt_read) && (mgmt_address == stall_addr);
            default: mgmt_waitrequest = 1'b0;
        endcase
    end

    // Bus monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cnt++;
            if (done) done_cnt++;
            if (mgmt_read) rd_cycles++;
            if (prev_stall && mgmt_write)
                check("stall_hold", {mgmt_address, mgmt_writedata}, {prev_addr, prev_data});
            prev_stall = mgmt_write && mgmt_waitrequest;
            prev_addr  = mgmt_address;
            prev_data  = mgmt_writedata;
            if (mgmt_write && !mgmt_waitrequest) begin
                wr_cnt++;
                mem[mgmt_address] = mgmt_writedata;
                if (sb.size() == 0) begin
                    check("unexpected_wr", {1'b1, mgmt_address, mgmt_writedata}, 64'h0);
                end else begin
                    check("wr", {mgmt_address, mgmt_writedata}, sb.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [5:0] a, input logic [31:0] d, input logic l);
        int   n  = 0;
        logic ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_last  = l;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #2;
            n++;
        end
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        check("cmd_accept", ok, 1);
    endtask

    task automatic run_burst();
        sb.push_back({6'h00, 32'h0});
        foreach (b_addr[i]) sb.push_back({b_addr[i], b_data[i]});
        sb.push_back({6'h02, 32'h1});
        foreach (b_addr[i]) begin
            send(b_addr[i], b_data[i], 1'b0);
            if (i == 0) check("clr_error", error, 0);
        end
        send(6'h3f, 32'hFFFF_FFFF, 1'b1);
        if (b_addr.size() == 0) check("clr_error", error, 0);
        check("first_wr_latency", {mgmt_write, mgmt_address}, {1'b1, 6'h00});
    endtask

    task automatic wait_done(input int bound, output logic ok, output int n);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < bound) begin
            cyc(1);
            n++;
            ok = done;
        end
    endtask

    task automatic wait_err(input int bound, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < bound) begin
            cyc(1);
            n++;
            ok = error;
        end
    endtask

    task automatic wait_sb(input int bound, output logic ok);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            cyc(1);
            n++;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic wait_wr_addr(input logic [5:0] a, input int bound, output logic ok);
        int n = 0;
        ok = mgmt_write && (mgmt_address == a);
        while (!ok && n < bound) begin
            cyc(1);
            n++;
            ok = mgmt_write && (mgmt_address == a);
        end
    endtask

    initial begin
        logic ok;
        int   n;
        int   d0;
        int   w0;
        int   a0;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_last = 1'b0;
        pll_locked = 1'b0;
        cyc(3);
        check("rst_ready", cmd_ready, 1);
        check("rst_write", mgmt_write, 0);
        check("rst_read", mgmt_read, 0);
        check("rst_status", {busy, done, error, err_code}, 5'b0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_ready", cmd_ready, 1);

        // 1: nominal burst, lock rises 10 cycles after START
        b_addr = '{6'h04, 6'h05};
        b_data = '{32'h0000_0808, 32'h0002_0303};
        d0 = done_cnt; w0 = wr_cnt;
        run_burst();
        wait_sb(100, ok);
        check("t1_writes_drained", ok, 1);
        cyc(10);
        pll_locked = 1'b1;
        wait_done(400, ok, n);
        check("t1_done_latency", n, 258);
        cyc(2);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_wr_count", wr_cnt - w0, 4);
        check("t1_status", {busy, error}, 2'b00);

        // 2: five stall cycles per transfer
        wrq_mode = 1;
        d0 = done_cnt; w0 = wr_cnt;
        run_burst();
        wait_done(1000, ok, n);
        check("t2_done", ok, 1);
        cyc(2);
        check("t2_wr_count", wr_cnt - w0, 4);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_done_once", done_cnt - d0, 1);

        // 3: START stuck in waitrequest
        wrq_mode = 2; stall_addr = 6'h02;
        run_burst();
        wait_wr_addr(6'h02, 200, ok);
        check("t3_start_seen", ok, 1);
        n = 0; ok = 1'b0;
        while (!ok && n < 1100) begin
            cyc(1);
            n++;
            ok = error;
        end
        check("t3_timeout_cycles", n, 1024);
        check("t3_err_code", err_code, 1);
        check("t3_write_low", mgmt_write, 0);
        check("t3_start_pending", sb.size(), 1);
        sb.delete();
        cyc(1);
        check("t3_ready_back", cmd_ready, 1);
        check("t3_err_sticky", {error, busy}, 2'b10);

        // 4a: 15 words plus terminator; an extra word is held off
        wrq_mode = 0;
        b_addr.delete(); b_data.delete();
        for (int i = 0; i < 15; i++) begin
            b_addr.push_back(6'(3 + (i % 3)));
            b_data.push_back({16'hC0DE, 16'(i)});
        end
        d0 = done_cnt; w0 = wr_cnt;
        run_burst();
        check("t4_ready_low", cmd_ready, 0);
        a0 = acc_cnt;
        cmd_valid = 1'b1; cmd_addr = 6'h05; cmd_data = 32'hDEAD_BEEF;
        cyc(20);
        check("t4_held", acc_cnt - a0, 0);
        cmd_valid = 1'b0;
        wait_done(600, ok, n);
        check("t4_done", ok, 1);
        cyc(2);
        check("t4_wr_count", wr_cnt - w0, 17);
        check("t4_sb_empty", sb.size(), 0);

        // 4b: terminator-only burst
        b_addr.delete(); b_data.delete();
        w0 = wr_cnt;
        run_burst();
        wait_done(600, ok, n);
        check("t4b_done", ok, 1);
        cyc(2);
        check("t4b_wr_count", wr_cnt - w0, 2);

        // 4c: sixteen data words fill the FIFO
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) send(6'h03, 32'(i), 1'b0);
        check("t4c_full_ready", {cmd_ready, busy}, 2'b01);
        a0 = acc_cnt;
        cmd_valid = 1'b1; cmd_last = 1'b1;
        cyc(20);
        check("t4c_no_accept", acc_cnt - a0, 0);
        check("t4c_no_write", wr_cnt - w0, 0);
        cmd_valid = 1'b0; cmd_last = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("t4c_ready_after_rst", cmd_ready, 1);

        // 5a: lock toggles every 100 cycles
        pll_locked = 1'b0;
        b_addr = '{6'h03};
        b_data = '{32'h0000_0101};
        d0 = done_cnt;
        run_burst();
        n = 0; ok = 1'b0;
        while (!ok && n < 3000) begin
            cyc(1);
            n++;
            if (n % 100 == 0) pll_locked = ~pll_locked;
            ok = error;
        end
        check("t5_lock_err", ok, 1);
        check("t5_err_code", err_code, 2);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_sb_empty", sb.size(), 0);

        // 5b: reset while a user write is stalled
        pll_locked = 1'b1;
        wrq_mode = 2; stall_addr = 6'h04;
        b_addr = '{6'h04};
        b_data = '{32'h0000_0808};
        run_burst();
        wait_wr_addr(6'h04, 50, ok);
        check("t5b_wr_seen", ok, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5b_async_drop", {mgmt_write, busy, cmd_ready, done, error}, 5'b00100);
        check("t5b_pending", sb.size(), 2);
        sb.delete();
        cyc(2);
        rst_n = 1'b1;
        wrq_mode = 0;
        cyc(2);

`ifdef PLL_CFG_READBACK_EN
        // 6: readback mismatch
        rd_corrupt = 1'b1;
        b_addr = '{6'h04};
        b_data = '{32'h0000_0808};
        run_burst();
        wait_err(200, ok);
        check("t6_err_seen", ok, 1);
        check("t6_err_code", err_code, 3);
        check("t6_start_pending", sb.size(), 1);
        sb.delete();
        rd_corrupt = 1'b0;
        cyc(2);
        check("rd_seen", rd_cycles > 0, 1);
`else
        check("no_read", rd_cycles, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
